counter_ctrl_193: RTL

COUNTER_CTRL_193 -- requirements
Module: counter_ctrl_193

---
 rtl/cnt_ctrl_pkg.sv | 26 ++
 rtl/cnt_ctrl_if.sv | 24 ++
 rtl/cnt_ctrl_prio.sv | 25 ++
 rtl/counter_ctrl_193.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cnt_ctrl_pkg.sv
// Shared types and idle levels for the cascaded 74x193 counter controller.
package cnt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UP_LO,
        ST_DN_LO,
        ST_LD_LO,
        ST_CLR_HI,
        ST_SETTLE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_CLR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } op_t;

    localparam logic CPU_IDLE = 1'b1;
    localparam logic CPD_IDLE = 1'b1;
    localparam logic PL_IDLE  = 1'b1;
    localparam logic MR_IDLE  = 1'b0;

endpackage

// File: rtl/cnt_ctrl_if.sv
// Request/status bus between a host and the counter controller.
interface cnt_ctrl_if;

    logic       req_clr;
    logic       req_load;
    logic       req_inc;
    logic       req_dec;
    logic [7:0] load_data;
    logic       ready;
    logic       done;
    logic [7:0] value;
    logic       err;

    modport master (
        output req_clr, req_load, req_inc, req_dec, load_data,
        input  ready, done, value, err
    );

    modport slave (
        input  req_clr, req_load, req_inc, req_dec, load_data,
        output ready, done, value, err
    );

endinterface

// File: rtl/cnt_ctrl_prio.sv
// Fixed-priority request selection: clr > load > inc > dec; inc with dec cancels to NOP.
module cnt_ctrl_prio
    import cnt_ctrl_pkg::*;
(
    input  logic req_clr,
    input  logic req_load,
    input  logic req_inc,
    input  logic req_dec,
    output op_t  op
);

    always_comb begin
        op = OP_NOP;
        if (req_clr) begin
            op = OP_CLR;
        end else if (req_load) begin
            op = OP_LOAD;
        end else if (req_inc && !req_dec) begin
            op = OP_INC;
        end else if (req_dec && !req_inc) begin
            op = OP_DEC;
        end
    end

endmodule

// File: rtl/counter_ctrl_193.sv
// Drives a cascaded 74x193 pair one operation at a time; every output is a flop.
// Define CNT_CTRL_CHECK_EN to compare cnt_q with the shadow value in the done cycle (sticky err).
module counter_ctrl_193
    import cnt_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    cnt_ctrl_if.slave        bus,
    output logic             cnt_cpu,
    output logic             cnt_cpd,
    output logic             cnt_pl,
    output logic             cnt_mr,
    output logic [7:0]       cnt_d,
    input  logic [7:0]       cnt_q
);

    state_t     state_q, state_d;
    logic       cpu_q, cpu_d;
    logic       cpd_q, cpd_d;
    logic       pl_q, pl_d;
    logic       mr_q, mr_d;
    logic [7:0] cnt_d_q, cnt_d_d;
    logic [7:0] value_q, value_d;
    logic       done_q, done_d;
    logic       ready_q, ready_d;
    logic       any_req;
    op_t        op;

    cnt_ctrl_prio u_prio (
        .req_clr  (bus.req_clr),
        .req_load (bus.req_load),
        .req_inc  (bus.req_inc),
        .req_dec  (bus.req_dec),
        .op       (op)
    );

    assign any_req = bus.req_clr | bus.req_load | bus.req_inc | bus.req_dec;

    // Each op drives its strobe for one state, then SETTLE lets the counter settle before done.
    always_comb begin
        state_d = state_q;
        cpu_d   = CPU_IDLE;
        cpd_d   = CPD_IDLE;
        pl_d    = PL_IDLE;
        mr_d    = MR_IDLE;
        cnt_d_d = cnt_d_q;
        value_d = value_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ready_q && any_req) begin
                    case (op)
                        OP_CLR: begin
                            state_d = ST_CLR_HI;
                            mr_d    = 1'b1;
                        end
                        OP_LOAD: begin
                            state_d = ST_LD_LO;
                            pl_d    = 1'b0;
                            cnt_d_d = bus.load_data;
                        end
                        OP_INC: begin
                            state_d = ST_UP_LO;
                            cpu_d   = 1'b0;
                        end
                        OP_DEC: begin
                            state_d = ST_DN_LO;
                            cpd_d   = 1'b0;
                        end
                        default: state_d = ST_SETTLE;
                    endcase
                end
            end
            ST_UP_LO: begin
                state_d = ST_SETTLE;
                value_d = value_q + 8'd1;
            end
            ST_DN_LO: begin
                state_d = ST_SETTLE;
                value_d = value_q - 8'd1;
            end
            ST_LD_LO: begin
                state_d = ST_SETTLE;
                value_d = cnt_d_q;
            end
            ST_CLR_HI: begin
                state_d = ST_SETTLE;
                value_d = 8'h00;
            end
            ST_SETTLE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Reset forces every strobe to idle except master reset, which masks any count edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cpu_q   <= CPU_IDLE;
            cpd_q   <= CPD_IDLE;
            pl_q    <= PL_IDLE;
            mr_q    <= 1'b1;
            cnt_d_q <= 8'h00;
            value_q <= 8'h00;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cpu_q   <= cpu_d;
            cpd_q   <= cpd_d;
            pl_q    <= pl_d;
            mr_q    <= mr_d;
            cnt_d_q <= cnt_d_d;
            value_q <= value_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

`ifdef CNT_CTRL_CHECK_EN
    logic err_q, err_d;

    // Comparing while in SETTLE makes err rise on the same edge as done.
    always_comb begin
        err_d = err_q | ((state_q == ST_SETTLE) && (cnt_q != value_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_cnt_q;
    assign unused_cnt_q = ^cnt_q;
    assign bus.err      = 1'b0;
`endif

    assign cnt_cpu   = cpu_q;
    assign cnt_cpd   = cpd_q;
    assign cnt_pl    = pl_q;
    assign cnt_mr    = mr_q;
    assign cnt_d     = cnt_d_q;
    assign bus.value = value_q;
    assign bus.done  = done_q;
    assign bus.ready = ready_q;

endmodule
